addsub_pipe: RTL and testbench

//  Parametrised, pipelined add/subtract unit for the ALU datapath. It is the

---
 rtl/addsub_pipe.sv | 159 +++++++++++++++
 tb/tb_addsub_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Pipelined add/sub/rsub/cmp unit: WIDTH split into STAGES slices, one slice
// per stage with the carry registered between stages; valid/ready on both ends.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cbout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_RSUB = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b11;

  logic              adv;

  // stage registers
  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  x_q  [STAGES];
  logic [WIDTH-1:0]  y_q  [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [1:0]        op_q [STAGES];
  logic              c_q  [STAGES];

  // stage inputs and next values
  logic [STAGES-1:0] v_in;
  logic [WIDTH-1:0]  x_in  [STAGES];
  logic [WIDTH-1:0]  y_in  [STAGES];
  logic [WIDTH-1:0]  s_in  [STAGES];
  logic [WIDTH-1:0]  a_in  [STAGES];
  logic [1:0]        op_in [STAGES];
  logic              c_in  [STAGES];
  logic [WIDTH-1:0]  s_nx  [STAGES];
  logic [STAGES-1:0] c_nx;
  logic [SW:0]       sl    [STAGES];

  logic [WIDTH-1:0]  x0, y0;
  logic              c0;

  logic [WIDTH-1:0]  r_fin, res_fin;
  logic              cb_fin, ovf_fin;

  assign adv       = !v_q[L] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[L];

  // operand conditioning: everything becomes X + Y + cin
  always_comb begin
    x0 = a;
    y0 = ~b;
    c0 = 1'b1;
    case (op)
      OP_ADD: begin
        x0 = a;
        y0 = b;
        c0 = 1'b0;
      end
      OP_RSUB: begin
        x0 = b;
        y0 = ~a;
        c0 = 1'b1;
      end
      default: begin
        x0 = a;
        y0 = ~b;
        c0 = 1'b1;
      end
    endcase
  end

  always_comb begin
    v_in[0]  = in_valid;
    x_in[0]  = x0;
    y_in[0]  = y0;
    c_in[0]  = c0;
    s_in[0]  = '0;
    a_in[0]  = a;
    op_in[0] = op;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k]  = v_q[k-1];
      x_in[k]  = x_q[k-1];
      y_in[k]  = y_q[k-1];
      c_in[k]  = c_q[k-1];
      s_in[k]  = s_q[k-1];
      a_in[k]  = a_q[k-1];
      op_in[k] = op_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sl[k] = {1'b0, x_in[k][k*SW +: SW]} + {1'b0, y_in[k][k*SW +: SW]}
            + {{SW{1'b0}}, c_in[k]};
      s_nx[k] = s_in[k];
      s_nx[k][k*SW +: SW] = sl[k][SW-1:0];
      c_nx[k] = sl[k][SW];
    end
  end

  // flags come from the last stage's combinational sum so they register with it
  always_comb begin
    r_fin   = s_nx[L];
    cb_fin  = (op_in[L] == OP_ADD) ? c_nx[L] : ~c_nx[L];
    res_fin = (op_in[L] == OP_CMP) ? a_in[L] : r_fin;
    ovf_fin = (x_in[L][WIDTH-1] == y_in[L][WIDTH-1]) &&
              (r_fin[WIDTH-1] != x_in[L][WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        x_q[k]  <= '0;
        y_q[k]  <= '0;
        s_q[k]  <= '0;
        a_q[k]  <= '0;
        op_q[k] <= '0;
        c_q[k]  <= 1'b0;
      end
      result <= '0;
      cbout  <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
    end else if (adv) begin
      v_q <= v_in;
      for (int k = 0; k < STAGES; k++) begin
        x_q[k]  <= x_in[k];
        y_q[k]  <= y_in[k];
        s_q[k]  <= s_nx[k];
        a_q[k]  <= a_in[k];
        op_q[k] <= op_in[k];
        c_q[k]  <= c_nx[k];
      end
      // bubbles leave the visible outputs untouched
      if (v_in[L]) begin
        result <= res_fin;
        cbout  <= cb_fin;
        zero   <= (r_fin == '0);
        neg    <= r_fin[WIDTH-1];
        ovf    <= ovf_fin;
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe (32-bit, 4 stages): directed corner cases, stall,
// mid-flight reset and randomized traffic checked against an arithmetic model.
module tb_addsub_pipe;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cbout;
  logic         zero;
  logic         neg;
  logic         ovf;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cbout(cbout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  typedef struct {
    logic [W+3:0] v;
    int           acc;
  } exp_t;

  exp_t         sbq[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  bit           check_lat = 1'b0;
  bit           acc_flag = 1'b0;
  bit           ovr_en = 1'b0;
  logic [W+3:0] ovr_v = '0;
  bit           prev_stall = 1'b0;
  logic [W+4:0] prev_out = '0;

  // {result, cbout, zero, neg, ovf} from plain unsigned/signed arithmetic
  function automatic logic [W+3:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         cb;
    logic         ov;
    r  = '0;
    cb = 1'b0;
    ov = 1'b0;
    case (o)
      2'd0: begin
        full = {1'b0, x} + {1'b0, y};
        r    = full[W-1:0];
        cb   = full[W];
        ov   = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      2'd2: begin
        r  = y - x;
        cb = (y < x);
        ov = (x[W-1] != y[W-1]) && (r[W-1] != y[W-1]);
      end
      default: begin
        r  = x - y;
        cb = (x < y);
        ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
    endcase
    return {(o == 2'd3) ? x : r, cb, (r == '0), r[W-1], ov};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // one clock: observe handshakes at the falling edge, then return after the rising edge
  task automatic tick();
    exp_t         e;
    logic [W+4:0] now_out;
    @(negedge clk);
    cyc++;
    acc_flag = 1'b0;
    now_out  = {out_valid, result, cbout, zero, neg, ovf};
    if (!rst) begin
      if (prev_stall) chk("stall_hold", 64'(now_out), 64'(prev_out));
      chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          e = sbq.pop_front();
          chk("result_flags", 64'({result, cbout, zero, neg, ovf}), 64'(e.v));
          if (check_lat) chk("latency", 64'(cyc - e.acc), 64'(S));
        end
      end
      if (in_valid && in_ready) begin
        e.v   = ovr_en ? ovr_v : model(op, a, b);
        e.acc = cyc;
        sbq.push_back(e);
        acc_flag = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = now_out;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int t;
    t        = 0;
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    do begin
      tick();
      t++;
    end while (!acc_flag && t < 20);
    n_vec++;
    assert (acc_flag) else begin
      n_err++;
      $error("FAIL accept_timeout: got no accept expected accept within 20 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() > 0 && t < 80) begin
      tick();
      t++;
    end
    n_vec++;
    assert (sbq.size() == 0) else begin
      n_err++;
      $error("FAIL drain_timeout: got %0d outstanding expected 0", sbq.size());
    end
  endtask

  task automatic directed(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W+3:0] expv);
    ovr_en = 1'b1;
    ovr_v  = expv;
    issue(o, x, y);
    ovr_en = 1'b0;
    drain();
  endtask

  initial begin
    int i;
    int j;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 2'd0;
    a         = '0;
    b         = '0;
    #12;
    chk("reset_outputs", 64'({out_valid, result, cbout, zero, neg, ovf}), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // directed corner cases, expected values written out by hand
    check_lat = 1'b1;
    directed(2'd1, 32'h0000_000A, 32'h0000_0002, {32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0});
    directed(2'd1, 32'h0000_0002, 32'h0000_000A, {32'hFFFF_FFF8, 1'b1, 1'b0, 1'b1, 1'b0});
    directed(2'd2, 32'h0000_0002, 32'h0000_000A, {32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0});
    directed(2'd0, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0});
    directed(2'd0, 32'h7FFF_FFFF, 32'h0000_0001, {32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1});
    directed(2'd1, 32'h8000_0000, 32'h0000_0001, {32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1});
    directed(2'd3, 32'h00CD_0956, 32'h00CD_0956, {32'h00CD_0956, 1'b0, 1'b1, 1'b0, 1'b0});

    // six back-to-back ops with a three-cycle consumer stall in the middle
    check_lat = 1'b0;
    i = 0;
    j = 0;
    while (i < 6 && j < 40) begin
      in_valid  = 1'b1;
      op        = 2'($urandom_range(0, 3));
      a         = $urandom;
      b         = $urandom;
      out_ready = !(j >= 5 && j < 8);
      tick();
      if (acc_flag) i++;
      j++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_accepts", 64'(i), 64'(6));
    drain();

    // reset with three transactions in flight
    check_lat = 1'b1;
    issue(2'd0, 32'h1234_5678, 32'h1111_1111);
    issue(2'd1, 32'hDEAD_BEEF, 32'h0000_0001);
    issue(2'd2, 32'h0000_0005, 32'h0000_0009);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_outputs", 64'({out_valid, result, cbout, zero, neg, ovf}), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    sbq.delete();
    tick();
    chk("midrst_hold", 64'({out_valid, result, cbout, zero, neg, ovf}), 64'(0));
    rst = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("post_rst_idle", 64'(out_valid), 64'(0));
    directed(2'd1, 32'h0000_0064, 32'h0000_0014, {32'h0000_0050, 1'b0, 1'b0, 1'b0, 1'b0});

    // randomized traffic with random valid/ready
    check_lat = 1'b0;
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 2'($urandom_range(0, 3));
      a         = pick();
      b         = pick();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
